// File: rtl/key_click_mode.sv
`default_nettype none
// ============================================================================
// Module   : key_click_mode
// Brief    : Key-driven VGA display-mode selector. Key A advances the mode;
//            with KEY_DBL_CLICK_EN defined, a second key-A release inside the
//            double-click window returns to mode 0 instead. Key B steps the
//            mode back and always takes priority over key A.
// Config   : `define KEY_DBL_CLICK_EN to enable the double-click window
//            (IDLE/WAIT FSM plus a 25-bit window counter).
// Revision : 1.0 - initial release
// ============================================================================
module key_click_mode #(
    parameter int MODE_NUM = 6,
    parameter int WIN      = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flag_a,
    input  logic       flag_b,
    output logic [2:0] mode,
    output logic       upd,
    output logic       dbl,
    output logic       busy
);

    localparam logic [2:0]  c_MODE_MAX = 3'(MODE_NUM - 1);
    localparam logic [3:0]  c_MODE_NUM = 4'(MODE_NUM);
    localparam logic [24:0] c_WIN_LAST = 25'(WIN - 1);

    logic [2:0] r_mode;
    logic       r_upd;
    logic [2:0] w_mode_inc;
    logic [2:0] w_mode_dec;
    logic       w_mode_bad;
    logic [2:0] w_mode_nxt;
    logic       w_upd_nxt;

    // Wrapping neighbours of the current mode and the out-of-range detector
    always_comb begin
        w_mode_inc = (r_mode == c_MODE_MAX) ? 3'd0 : r_mode + 3'd1;
        w_mode_dec = (r_mode == 3'd0) ? c_MODE_MAX : r_mode - 3'd1;
        w_mode_bad = ({1'b0, r_mode} >= c_MODE_NUM);
    end

`ifdef KEY_DBL_CLICK_EN
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [24:0] r_cnt;
    logic [24:0] w_cnt_nxt;
    logic        r_dbl;
    logic        w_dbl_nxt;

    // State, window counter and double-click pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 25'd0;
            r_dbl   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dbl   <= w_dbl_nxt;
        end
    end

    // Next-state decode: key B cancels/steps back, key A in WAIT is a double
    // click, and window expiry with no key resolves a single click
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_upd_nxt   = 1'b0;
        w_dbl_nxt   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (flag_b) begin
                    w_mode_nxt = w_mode_dec;
                    w_upd_nxt  = 1'b1;
                end else if (flag_a) begin
                    w_state_nxt = c_ST_WAIT;
                    w_cnt_nxt   = 25'd0;
                end
            end
            c_ST_WAIT: begin
                w_cnt_nxt = r_cnt + 25'd1;
                if (flag_b) begin
                    w_mode_nxt  = w_mode_dec;
                    w_upd_nxt   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = 25'd0;
                end else if (flag_a) begin
                    // Every cycle spent in WAIT lies inside the window, the
                    // last one (cnt == WIN-1) included
                    w_mode_nxt  = 3'd0;
                    w_upd_nxt   = 1'b1;
                    w_dbl_nxt   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = 25'd0;
                end else if (r_cnt == c_WIN_LAST) begin
                    w_mode_nxt  = w_mode_inc;
                    w_upd_nxt   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = 25'd0;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = 25'd0;
            end
        endcase
        if (w_mode_bad) begin
            w_mode_nxt = 3'd0;
        end
    end

    assign busy = (r_state == c_ST_WAIT);
    assign dbl  = r_dbl;
`else
    logic w_unused_win;

    // Immediate decode: key B steps back, key A advances, both wrap
    always_comb begin
        w_mode_nxt = r_mode;
        w_upd_nxt  = 1'b0;
        if (flag_b) begin
            w_mode_nxt = w_mode_dec;
            w_upd_nxt  = 1'b1;
        end else if (flag_a) begin
            w_mode_nxt = w_mode_inc;
            w_upd_nxt  = 1'b1;
        end
        if (w_mode_bad) begin
            w_mode_nxt = 3'd0;
        end
    end

    // The window length only matters when double-click support is built in
    assign w_unused_win = ^c_WIN_LAST;
    assign busy = 1'b0;
    assign dbl  = 1'b0;
`endif

    // Registered mode and update pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= 3'd0;
            r_upd  <= 1'b0;
        end else begin
            r_mode <= w_mode_nxt;
            r_upd  <= w_upd_nxt;
        end
    end

    assign mode = r_mode;
    assign upd  = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_key_click_mode.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_click_mode
// Brief    : Directed bench for key_click_mode (WIN=8, MODE_NUM=6). Covers the
//            build selected by KEY_DBL_CLICK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_click_mode;

    logic       clk;
    logic       rst;
    logic       flag_a;
    logic       flag_b;
    logic [2:0] mode;
    logic       upd;
    logic       dbl;
    logic       busy;

    int total;
    int bad;

    key_click_mode #(
        .MODE_NUM (6),
        .WIN      (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .flag_a (flag_a),
        .flag_b (flag_b),
        .mode   (mode),
        .upd    (upd),
        .dbl    (dbl),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int m, input int u, input int d, input int b);
        chk({tag, ".mode"}, int'(mode), m);
        chk({tag, ".upd"},  int'(upd),  u);
        chk({tag, ".dbl"},  int'(dbl),  d);
        chk({tag, ".busy"}, int'(busy), b);
    endtask

    // One clock: present flags, let the edge sample them, then release them
    task automatic cyc(input logic a, input logic b);
        flag_a = a;
        flag_b = b;
        @(posedge clk);
        #1;
        flag_a = 1'b0;
        flag_b = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        flag_a = 1'b0;
        flag_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0);
        rst = 1'b0;
        cyc(1'b0, 1'b0);
        chk_all("idle", 0, 0, 0, 0);

`ifdef KEY_DBL_CLICK_EN
        // Step back 0 -> 5 -> 4 -> 3 -> 2
        cyc(1'b0, 1'b1);
        chk_all("b_wrap", 5, 1, 0, 0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk_all("b_to2", 2, 1, 0, 0);

        // Single click from 2: busy for cnt 0..7, then mode 3
        cyc(1'b1, 1'b0);
        chk_all("single_start", 2, 0, 0, 1);
        for (int i = 1; i < 8; i++) begin
            cyc(1'b0, 1'b0);
            chk_all("single_wait", 2, 0, 0, 1);
        end
        cyc(1'b0, 1'b0);
        chk_all("single_done", 3, 1, 0, 0);
        cyc(1'b0, 1'b0);
        chk_all("single_after", 3, 0, 0, 0);

        // Single click 3 -> 4
        cyc(1'b1, 1'b0);
        repeat (8) cyc(1'b0, 1'b0);
        chk_all("single_to4", 4, 1, 0, 0);

        // Double click with the second press at cnt == 7
        cyc(1'b1, 1'b0);
        repeat (7) cyc(1'b0, 1'b0);
        chk_all("dbl_edge_wait", 4, 0, 0, 1);
        cyc(1'b1, 1'b0);
        chk_all("dbl_done", 0, 1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0);
            chk_all("dbl_after", 0, 0, 0, 0);
        end

        // Step back wraps to 5, single click wraps to 0
        cyc(1'b0, 1'b1);
        chk_all("b_wrap2", 5, 1, 0, 0);
        cyc(1'b0, 1'b0);
        chk_all("b_once", 5, 0, 0, 0);
        cyc(1'b1, 1'b0);
        repeat (8) cyc(1'b0, 1'b0);
        chk_all("single_wrap", 0, 1, 0, 0);

        // Mode 3, key B at cnt 3 cancels the pending click
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk_all("b_to3", 3, 1, 0, 0);
        cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);
        chk_all("cancel_wait", 3, 0, 0, 1);
        cyc(1'b0, 1'b1);
        chk_all("cancel", 2, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0);
            chk_all("cancel_after", 2, 0, 0, 0);
        end

        // Both keys together from 1: key B wins, no window opened
        cyc(1'b0, 1'b1);
        chk_all("b_to1", 1, 1, 0, 0);
        cyc(1'b1, 1'b1);
        chk_all("both", 0, 1, 0, 0);
        cyc(1'b0, 1'b0);
        chk_all("both_after", 0, 0, 0, 0);

        // Reset during WAIT at cnt 4 discards the click
        cyc(1'b0, 1'b1);
        chk_all("pre_rst", 5, 1, 0, 0);
        cyc(1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b0);
        chk_all("rst_wait", 5, 0, 0, 1);
        #1 rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0);
            chk_all("rst_after", 0, 0, 0, 0);
        end
`else
        // Mode 1, then two key-A presses three cycles apart
        cyc(1'b1, 1'b0);
        chk_all("a_to1", 1, 1, 0, 0);
        cyc(1'b0, 1'b0);
        chk_all("a_to1_after", 1, 0, 0, 0);
        cyc(1'b1, 1'b0);
        chk_all("a_to2", 2, 1, 0, 0);
        cyc(1'b0, 1'b0);
        chk_all("a_to2_after", 2, 0, 0, 0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk_all("a_to3", 3, 1, 0, 0);
        cyc(1'b0, 1'b0);
        chk_all("a_to3_after", 3, 0, 0, 0);

        // Advance through 4, 5 and wrap to 0
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk_all("a_to5", 5, 1, 0, 0);
        cyc(1'b1, 1'b0);
        chk_all("a_wrap", 0, 1, 0, 0);

        // Step back wraps 0 -> 5, then 4
        cyc(1'b0, 1'b1);
        chk_all("b_wrap", 5, 1, 0, 0);
        cyc(1'b0, 1'b0);
        chk_all("b_once", 5, 0, 0, 0);
        cyc(1'b0, 1'b1);
        chk_all("b_to4", 4, 1, 0, 0);

        // Down to 1, then both keys: key B wins
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk_all("b_to1", 1, 1, 0, 0);
        cyc(1'b1, 1'b1);
        chk_all("both", 0, 1, 0, 0);
        cyc(1'b0, 1'b0);
        chk_all("both_after", 0, 0, 0, 0);

        // Asynchronous reset mid-cycle clears everything at once
        cyc(1'b1, 1'b0);
        chk_all("pre_rst", 1, 1, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0);
        chk_all("rst_after", 0, 0, 0, 0);
        cyc(1'b1, 1'b0);
        chk_all("first_after_rst", 1, 1, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
